// File: rtl/ase_sim_local_mem_arb_pkg.sv
// Shared types and helpers for the local-memory Avalon-MM arbiter.
//   t_arb_state : arbiter FSM state
//   t_rd_tag    : outstanding read burst {owner id, beat count}
//   rr_pick     : round-robin winner search starting at a pointer, wrapping at n_req
//   rr_next     : pointer advance with wrap at n_req
// Widths are fixed for the largest supported slice: up to 8 requesters and
// burstcount fields up to 8 bits wide.
package ase_sim_local_mem_arb_pkg;

  localparam int ARB_MAX_REQ = 8;
  localparam int ARB_ID_W    = 3;
  localparam int ARB_BEATS_W = 8;

  typedef enum logic {
    ARB      = 1'b0,
    WR_BURST = 1'b1
  } t_arb_state;

  typedef struct packed {
    logic [ARB_ID_W-1:0]    id;
    logic [ARB_BEATS_W-1:0] beats;
  } t_rd_tag;

  typedef struct packed {
    logic                valid;
    logic [ARB_ID_W-1:0] id;
  } t_rr_pick;

  function automatic logic [ARB_ID_W-1:0] rr_next(input logic [ARB_ID_W-1:0] id,
                                                  input logic [ARB_ID_W:0]   n_req);
    logic [ARB_ID_W:0] nxt;
    nxt = {1'b0, id} + {{ARB_ID_W{1'b0}}, 1'b1};
    if (nxt >= n_req) nxt = '0;
    return nxt[ARB_ID_W-1:0];
  endfunction

  // Scan from highest offset down so the lowest offset from ptr wins.
  function automatic t_rr_pick rr_pick(input logic [ARB_MAX_REQ-1:0] req,
                                       input logic [ARB_ID_W-1:0]    ptr,
                                       input logic [ARB_ID_W:0]      n_req);
    t_rr_pick          pick;
    logic [ARB_ID_W:0] k_w;
    logic [ARB_ID_W:0] idx;
    pick = '0;
    for (int k = ARB_MAX_REQ - 1; k >= 0; k--) begin
      k_w = k[ARB_ID_W:0];
      idx = {1'b0, ptr} + k_w;
      if (idx >= n_req) idx = idx - n_req;
      if ((k_w < n_req) && req[idx[ARB_ID_W-1:0]]) begin
        pick.valid = 1'b1;
        pick.id    = idx[ARB_ID_W-1:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/ase_sim_local_mem_rd_tag_fifo.sv
// Synchronous FIFO of read tags tracking outstanding read bursts in issue order.
//   clk, reset_n     : clock, async active-low reset (empties the FIFO)
//   push, push_tag   : enqueue; accepted when not full or when popping in the same cycle
//   pop, head_tag    : dequeue / oldest entry (valid when !empty)
//   full, empty      : occupancy flags
module ase_sim_local_mem_rd_tag_fifo
  import ase_sim_local_mem_arb_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic    clk,
  input  logic    reset_n,
  input  logic    push,
  input  t_rd_tag push_tag,
  input  logic    pop,
  output t_rd_tag head_tag,
  output logic    full,
  output logic    empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  t_rd_tag           mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign head_tag = mem_q[rd_ptr_q];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_tag;
  end

endmodule

// File: rtl/ase_sim_local_mem_avmm_arbiter.sv
// Round-robin arbiter sharing one local-memory Avalon-MM bank among N_REQ requesters.
// Write bursts hold the grant until their last beat; read responses are routed back
// in issue order through a tag FIFO.
//   clk, reset_n                       : bank clock, async active-low reset
//   s_address/burstcount/writedata/byteenable, s_read, s_write : flattened per-requester command
//   s_waitrequest                      : per-requester backpressure
//   s_readdata, s_readdatavalid        : broadcast data, one-hot valid to the owner
//   m_*                                : single command/response port to the bank
//   grant_count                        : per-requester accepted-command counters (32 b each)
//   err_rd_orphan                      : sticky, read beat arrived with nothing outstanding
// Build option: define ASE_LOCAL_MEM_ARB_STATS_EN to implement grant_count (saturating);
// otherwise grant_count reads 0.
//
// state    | meaning
// ARB      | pick next eligible requester from rr_ptr
// WR_BURST | locked to lock_id until wr_remain beats of its write burst are accepted
module ase_sim_local_mem_avmm_arbiter
  import ase_sim_local_mem_arb_pkg::*;
#(
  parameter int N_REQ           = 4,
  parameter int ADDR_WIDTH      = 27,
  parameter int DATA_WIDTH      = 512,
  parameter int BURST_CNT_WIDTH = 7,
  parameter int RD_FIFO_DEPTH   = 16,
  parameter int DATA_N_BYTES    = DATA_WIDTH / 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [N_REQ*ADDR_WIDTH-1:0]      s_address,
  input  logic [N_REQ*BURST_CNT_WIDTH-1:0] s_burstcount,
  input  logic [N_REQ*DATA_WIDTH-1:0]      s_writedata,
  input  logic [N_REQ*DATA_N_BYTES-1:0]    s_byteenable,
  input  logic [N_REQ-1:0]                 s_read,
  input  logic [N_REQ-1:0]                 s_write,
  output logic [N_REQ-1:0]                 s_waitrequest,
  output logic [DATA_WIDTH-1:0]            s_readdata,
  output logic [N_REQ-1:0]                 s_readdatavalid,
  output logic [ADDR_WIDTH-1:0]            m_address,
  output logic [BURST_CNT_WIDTH-1:0]       m_burstcount,
  output logic [DATA_WIDTH-1:0]            m_writedata,
  output logic [DATA_N_BYTES-1:0]          m_byteenable,
  output logic                             m_read,
  output logic                             m_write,
  input  logic                             m_waitrequest,
  input  logic [DATA_WIDTH-1:0]            m_readdata,
  input  logic                             m_readdatavalid,
  output logic [N_REQ*32-1:0]              grant_count,
  output logic                             err_rd_orphan
);

  localparam logic [ARB_ID_W:0]          N_REQ_L = (ARB_ID_W + 1)'(N_REQ);
  localparam logic [BURST_CNT_WIDTH-1:0] BC_ONE  = BURST_CNT_WIDTH'(1);

  t_arb_state                 state_q, state_d;
  logic [ARB_ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [ARB_ID_W-1:0]        lock_id_q, lock_id_d;
  logic [BURST_CNT_WIDTH-1:0] wr_remain_q, wr_remain_d;
  logic [ARB_BEATS_W-1:0]     rd_cnt_q, rd_cnt_d;
  logic                       err_rd_orphan_q, err_rd_orphan_d;

  logic [ARB_MAX_REQ-1:0]     s_write_ext;
  logic [ARB_MAX_REQ-1:0]     eligible;
  t_rr_pick                   pick;
  logic                       gnt_valid, gnt_is_write, accept;
  logic [ARB_ID_W-1:0]        gnt_id;
  logic [BURST_CNT_WIDTH-1:0] gnt_bc_eff;

  logic    fifo_push, fifo_pop, fifo_full, fifo_empty, rd_last;
  t_rd_tag push_tag, head_tag;

  // A port with both strobes high is treated as a write.
  always_comb begin
    s_write_ext = '0;
    eligible    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      s_write_ext[i] = s_write[i];
      eligible[i]    = s_write[i] | (s_read[i] & ~fifo_full);
    end
  end

  // Grant is gated by reset so the bank sees no command while reset_n is low.
  always_comb begin
    pick      = rr_pick(eligible, rr_ptr_q, N_REQ_L);
    gnt_id    = pick.id;
    gnt_valid = pick.valid;
    if (state_q == WR_BURST) begin
      gnt_id    = lock_id_q;
      gnt_valid = s_write_ext[lock_id_q];
    end
    if (!reset_n) gnt_valid = 1'b0;
    gnt_is_write = s_write_ext[gnt_id];
    accept       = gnt_valid & ~m_waitrequest;
  end

  always_comb begin
    m_address     = '0;
    m_burstcount  = '0;
    m_writedata   = '0;
    m_byteenable  = '0;
    s_waitrequest = '1;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_id == ARB_ID_W'(i)) begin
        m_address     = s_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        m_burstcount  = s_burstcount[i*BURST_CNT_WIDTH +: BURST_CNT_WIDTH];
        m_writedata   = s_writedata[i*DATA_WIDTH +: DATA_WIDTH];
        m_byteenable  = s_byteenable[i*DATA_N_BYTES +: DATA_N_BYTES];
        s_waitrequest[i] = ~gnt_valid | m_waitrequest;
      end
    end
    m_write    = gnt_valid & gnt_is_write;
    m_read     = gnt_valid & ~gnt_is_write;
    gnt_bc_eff = (m_burstcount == '0) ? BC_ONE : m_burstcount;
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lock_id_d   = lock_id_q;
    wr_remain_d = wr_remain_q;
    fifo_push   = 1'b0;
    push_tag.id    = gnt_id;
    push_tag.beats = ARB_BEATS_W'(gnt_bc_eff);
    case (state_q)
      ARB: begin
        if (accept) begin
          if (gnt_is_write) begin
            if (gnt_bc_eff > BC_ONE) begin
              wr_remain_d = gnt_bc_eff - BC_ONE;
              lock_id_d   = gnt_id;
              state_d     = WR_BURST;
            end else begin
              rr_ptr_d = rr_next(gnt_id, N_REQ_L);
            end
          end else begin
            fifo_push = 1'b1;
            rr_ptr_d  = rr_next(gnt_id, N_REQ_L);
          end
        end
      end
      WR_BURST: begin
        if (accept) begin
          if (wr_remain_q == BC_ONE) begin
            wr_remain_d = '0;
            rr_ptr_d    = rr_next(lock_id_q, N_REQ_L);
            state_d     = ARB;
          end else begin
            wr_remain_d = wr_remain_q - BC_ONE;
          end
        end
      end
      default: state_d = ARB;
    endcase
  end

  // Read return: beats go to the head tag's owner; the tag retires on its last beat.
  always_comb begin
    rd_cnt_d        = rd_cnt_q;
    err_rd_orphan_d = err_rd_orphan_q;
    fifo_pop        = 1'b0;
    s_readdatavalid = '0;
    rd_last         = ((rd_cnt_q + ARB_BEATS_W'(1)) == head_tag.beats);
    if (m_readdatavalid && reset_n) begin
      if (fifo_empty) begin
        err_rd_orphan_d = 1'b1;
      end else begin
        for (int i = 0; i < N_REQ; i++) begin
          if (head_tag.id == ARB_ID_W'(i)) s_readdatavalid[i] = 1'b1;
        end
        if (rd_last) begin
          fifo_pop = 1'b1;
          rd_cnt_d = '0;
        end else begin
          rd_cnt_d = rd_cnt_q + ARB_BEATS_W'(1);
        end
      end
    end
  end

  assign s_readdata    = m_readdata;
  assign err_rd_orphan = err_rd_orphan_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ARB;
      rr_ptr_q        <= '0;
      lock_id_q       <= '0;
      wr_remain_q     <= '0;
      rd_cnt_q        <= '0;
      err_rd_orphan_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      lock_id_q       <= lock_id_d;
      wr_remain_q     <= wr_remain_d;
      rd_cnt_q        <= rd_cnt_d;
      err_rd_orphan_q <= err_rd_orphan_d;
    end
  end

  ase_sim_local_mem_rd_tag_fifo #(
    .DEPTH (RD_FIFO_DEPTH)
  ) u_rd_tag_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (fifo_push),
    .push_tag (push_tag),
    .pop      (fifo_pop),
    .head_tag (head_tag),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

`ifdef ASE_LOCAL_MEM_ARB_STATS_EN
  logic [31:0] grant_cnt_q [N_REQ];
  logic [31:0] grant_cnt_d [N_REQ];

  // Only ARB-state accepts count: a read or the first beat of a write.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      grant_cnt_d[i] = grant_cnt_q[i];
      if (accept && (state_q == ARB) && (gnt_id == ARB_ID_W'(i)) &&
          (grant_cnt_q[i] != 32'hFFFF_FFFF)) begin
        grant_cnt_d[i] = grant_cnt_q[i] + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_REQ; i++) grant_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) grant_cnt_q[i] <= grant_cnt_d[i];
    end
  end

  always_comb begin
    grant_count = '0;
    for (int i = 0; i < N_REQ; i++) grant_count[i*32 +: 32] = grant_cnt_q[i];
  end
`else
  assign grant_count = '0;
`endif

endmodule
